// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths and FSM states for ram1024x4_arbiter.
package ram_arb_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;
  localparam int RAM_DEPTH = 1024;
  typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant; last points at the most recently granted port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  always_comb begin
    gnt[0] = en && req[0] && (!req[1] || last);
    gnt[1] = en && req[1] && (!req[0] || !last);
  end
  always_ff @(posedge clk) last <= rst ? 1'b1 : (|gnt ? gnt[1] : last);
endmodule

// File: rtl/ram1024x4_arbiter.sv
// ram1024x4_arbiter: two-requester round-robin front end for an external SB_RAM1024x4.
// Define RAM1024_ARB_CLEAR_EN to fill the RAM with CLEAR_VALUE after every reset.
module ram1024x4_arbiter
  import ram_arb_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLEAR_VALUE = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_re,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  state_t state, state_nxt;
  logic [1:0] gnt;
  logic [ADDR_W-1:0] cnt, addr;
  logic [DATA_W-1:0] wdata;
  logic run, clr, sel, wr, rd, rsp_pend, rsp_tag;
`ifdef RAM1024_ARB_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
  always_ff @(posedge clk) cnt <= (rst || state != CLEAR) ? '0 : cnt + 1'b1;
  assign clr = !rst && state == CLEAR;
  always_comb state_nxt = (state == CLEAR && cnt != ADDR_W'(RAM_DEPTH - 1)) ? CLEAR : RUN;
`else
  localparam state_t RST_STATE = RUN;
  assign cnt = '0;
  assign clr = 1'b0;
  always_comb state_nxt = RUN;
`endif
  always_ff @(posedge clk) state <= rst ? RST_STATE : state_nxt;
  assign run = !rst && state == RUN;
  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (run),
    .req ({p1_req_valid, p0_req_valid}),
    .gnt (gnt)
  );
  always_comb begin
    sel = gnt[1];
    addr = sel ? p1_req_addr : p0_req_addr;
    wdata = sel ? p1_req_wdata : p0_req_wdata;
    wr = |gnt && (sel ? p1_req_we : p0_req_we);
    rd = |gnt && !(sel ? p1_req_we : p0_req_we);
    p0_req_ready = gnt[0];
    p1_req_ready = gnt[1];
    ram_we = clr || wr;
    ram_waddr = clr ? cnt : (wr ? addr : '0);
    ram_wdata = clr ? CLEAR_VALUE : (wr ? wdata : '0);
    ram_re = rd;
    ram_raddr = rd ? addr : '0;
    busy = clr;
  end
  // Tag remembers which port owns the read data the RAM returns next cycle.
  always_ff @(posedge clk) begin
    rsp_pend <= !rst && rd;
    rsp_tag <= rst ? 1'b0 : sel;
  end
  always_comb begin
    p0_rsp_valid = !rst && rsp_pend && !rsp_tag;
    p1_rsp_valid = !rst && rsp_pend && rsp_tag;
    p0_rsp_rdata = p0_rsp_valid ? ram_rdata : '0;
    p1_rsp_rdata = p1_rsp_valid ? ram_rdata : '0;
  end
endmodule

// File: tb/tb_ram1024x4_arbiter.sv
// tb_ram1024x4_arbiter: directed bench with a response scoreboard and a behavioural RAM.
module tb_ram1024x4_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic p0_req_valid = 1'b0, p0_req_we = 1'b0, p1_req_valid = 1'b0, p1_req_we = 1'b0;
  logic [9:0] p0_req_addr = '0, p1_req_addr = '0;
  logic [3:0] p0_req_wdata = '0, p1_req_wdata = '0;
  logic p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid;
  logic [3:0] p0_rsp_rdata, p1_rsp_rdata, ram_wdata;
  logic [3:0] ram_rdata = '0;
  logic [9:0] ram_raddr, ram_waddr;
  logic ram_re, ram_we, busy;
  logic [3:0] mem [1024];
  logic [4:0] exp_q [$];
  logic [4:0] e;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ram1024x4_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_re(ram_re), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // Registered-read RAM standing in for the external SB_RAM1024x4.
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [9:0] a0, input logic [3:0] d0,
                       input logic v1, input logic we1, input logic [9:0] a1, input logic [3:0] d1);
    p0_req_valid = v0; p0_req_we = we0; p0_req_addr = a0; p0_req_wdata = d0;
    p1_req_valid = v1; p1_req_we = we1; p1_req_addr = a1; p1_req_wdata = d1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk);
    chk("idle_ram_en", {30'b0, ram_re, ram_we}, 0);
    tick;
    chk("queue_drained", exp_q.size(), 0);
  endtask

`ifdef RAM1024_ARB_CLEAR_EN
  task automatic clear_cycle(input int i);
    @(negedge clk);
    chk("clear_cycle", {busy, ram_we, p0_req_ready, p1_req_ready, ram_wdata, ram_waddr},
        {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 10'(i)});
    tick;
  endtask
`endif

  // Monitor: every response the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (p0_rsp_valid || p1_rsp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", {30'b0, p1_rsp_valid, p0_rsp_valid}, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_route", {30'b0, p1_rsp_valid, p0_rsp_valid}, e[4] ? 2 : 1);
        chk("rsp_data", e[4] ? p1_rsp_rdata : p0_rsp_rdata, e[3:0]);
      end
    end
  end

  initial begin
    drive(1, 0, 10'h3FF, 4'h0, 1, 1, 10'h001, 4'h7);
    tick;
    tick;
    @(negedge clk);
    chk("rst_ctrl", {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, ram_re, ram_we, busy}, 0);
    chk("rst_data", {ram_raddr, ram_waddr, ram_wdata, p0_rsp_rdata, p1_rsp_rdata}, 0);
    tick;
    rst = 1'b0;
`ifdef RAM1024_ARB_CLEAR_EN
    drive(1, 1, 10'h005, 4'h0, 1, 1, 10'h006, 4'h0);
    for (int i = 0; i < 500; i++) clear_cycle(i);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) clear_cycle(i);
    @(negedge clk);
    chk("clear_done_busy", busy, 0);
    chk("clear_done_ready", {p1_req_ready, p0_req_ready}, 2'b01);
    tick;
`endif
    drive(1, 1, 10'h3FF, 4'hA, 0, 0, '0, '0);
    @(negedge clk);
    chk("wr_ready", {p1_req_ready, p0_req_ready}, 2'b01);
    chk("wr_ram", {ram_we, ram_re, ram_wdata, ram_waddr}, {1'b1, 1'b0, 4'hA, 10'h3FF});
    tick;
    drive(1, 0, 10'h3FF, 4'h0, 0, 0, '0, '0);
    @(negedge clk);
    chk("rd_ram", {ram_re, ram_we, ram_raddr}, {1'b1, 1'b0, 10'h3FF});
    exp_q.push_back({1'b0, 4'hA});
    tick;
    idle_drain;
    drive(0, 0, '0, '0, 1, 1, 10'h010, 4'h5);
    @(negedge clk);
    chk("pre_wr0", {p1_req_ready, ram_we}, 2'b11);
    tick;
    drive(0, 0, '0, '0, 1, 1, 10'h020, 4'hC);
    @(negedge clk);
    chk("pre_wr1", {p1_req_ready, ram_we}, 2'b11);
    tick;
    drive(1, 0, 10'h010, 4'h0, 1, 0, 10'h020, 4'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_grant", {p1_req_ready, p0_req_ready}, (k % 2) ? 2'b10 : 2'b01);
      exp_q.push_back((k % 2) ? {1'b1, 4'hC} : {1'b0, 4'h5});
      tick;
    end
    idle_drain;
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, '0, '0, 1, 1, 10'(256 + k), 4'(k + 1));
      @(negedge clk);
      chk("p1_stream", {p1_req_ready, ram_we, ram_wdata, ram_waddr}, {1'b1, 1'b1, 4'(k + 1), 10'(256 + k)});
      tick;
    end
    drive(1, 0, 10'h102, 4'h0, 0, 0, '0, '0);
    @(negedge clk);
    chk("rd_after_stream", p0_req_ready, 1);
    exp_q.push_back({1'b0, 4'h3});
    tick;
    idle_drain;
    drive(1, 0, 10'h3FF, 4'h0, 0, 0, '0, '0);
    @(negedge clk);
    chk("rd_before_rst", {ram_re, p0_req_ready}, 2'b11);
    tick;
    rst = 1'b1;
    drive(1, 1, 10'h001, 4'h1, 1, 1, 10'h002, 4'h2);
    @(negedge clk);
    chk("mid_rst_ctrl", {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, ram_re, ram_we, busy}, 0);
    chk("mid_rst_data", {ram_raddr, ram_waddr, ram_wdata, p0_rsp_rdata, p1_rsp_rdata}, 0);
    tick;
    rst = 1'b0;
`ifdef RAM1024_ARB_CLEAR_EN
    for (int i = 0; i < 1024; i++) tick;
`endif
    @(negedge clk);
    chk("post_rst_tie", {p1_req_ready, p0_req_ready}, 2'b01);
    chk("post_rst_rsp", {p1_rsp_valid, p0_rsp_valid}, 0);
    tick;
    idle_drain;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram1024x4_arbiter.md
RAM1024X4_ARBITER -- requirements
Module: ram1024x4_arbiter

Interface
REQ-001 Parameter: CLEAR_VALUE, default 4'h0, nibble written to every location during the clear sequence.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  single clock; RAM RCLK and WCLK both tie to clk.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 pN_req_valid  in  1  requester N (N=0,1) has a pending access.
REQ-006 pN_req_ready  out  1  access accepted this cycle.
REQ-007 pN_req_we  in  1  1=write, 0=read.
REQ-008 pN_req_addr  in  10  nibble address.
REQ-009 pN_req_wdata  in  4  write data.
REQ-010 pN_rsp_valid  out  1  read data valid for requester N.
REQ-011 pN_rsp_rdata  out  4  read data.
REQ-012 ram_raddr / ram_waddr  out  10  RAM addresses.
REQ-013 ram_re / ram_we  out  1  RAM read/write enables; RCLKE and WCLKE held 1.
REQ-014 ram_wdata  out  4  RAM write data.
REQ-015 ram_rdata  in  4  RAM registered read data, valid one cycle after ram_re.
REQ-016 busy  out  1  high while the clear sequence runs.

Function
REQ-017 FSM states: CLEAR, RUN; reset enters CLEAR when the clear feature is compiled in, otherwise RUN.
REQ-018 In RUN, at most one request is granted per cycle; pN_req_ready is combinational from valid and the arbitration state.
REQ-019 A handshake is pN_req_valid && pN_req_ready; the request fields drive the RAM ports in that same cycle (ram_we or ram_re asserted for one cycle).
REQ-020 Arbitration is round-robin: when both are valid, grant the port not granted last; the last-grant pointer updates only on a handshake; reset value points at p1, so p0 wins the first tie.
REQ-021 With one requester valid, that requester is granted every cycle (no idle bubbles).
REQ-022 A read handshake in cycle T produces pN_rsp_valid=1 and pN_rsp_rdata=ram_rdata for exactly cycle T+1, routed to the granted port via a one-bit tag register.
REQ-023 Writes produce no response.
REQ-024 A read at cycle T+1 of an address written at cycle T returns the new data.
REQ-025 Back-to-back reads from alternating ports give one rsp_valid per cycle with correct routing.
REQ-026 When neither port is valid, ram_re=0 and ram_we=0.

Reset
REQ-027 On rst: pN_req_ready=0, pN_rsp_valid=0, pN_rsp_rdata=0, ram_re=0, ram_we=0, ram_* address/data=0, last-grant=p1, clear counter=0.
REQ-028 rst asserted mid-transaction drops any pending read response (no rsp_valid in the following cycle).
REQ-029 rst asserted mid-clear restarts the clear from address 0.

Configuration
REQ-030 Macro RAM1024_ARB_CLEAR_EN defined: after reset the FSM sits in CLEAR for exactly 1024 cycles, writing CLEAR_VALUE to addresses 0..1023 in order. During CLEAR, busy=1 and both pN_req_ready=0. It then enters RUN with busy=0.
REQ-031 Macro undefined: no clear counter, busy is tied to 0, and RUN is entered on the first cycle after reset.

Structure
REQ-032 Package ram_arb_pkg holds ADDR_W=10, DATA_W=4, RAM_DEPTH=1024 and the FSM state enum.
REQ-033 Sub-module rr_arb2 implements the two-input round-robin grant plus last-grant pointer; the top instantiates it once.
REQ-034 The block connects to one SB_RAM1024x4 instance in the enclosing level; it does not instantiate the RAM itself.

Verification
REQ-035 CLEAR_EN on, reset release -> busy=1 for 1024 cycles, ram_we=1 with ram_waddr 0..1023 and ram_wdata 4'h0, then busy=0 and the ready signals become live.
REQ-036 p0 writes 4'hA to address 10'h3FF, then p0 reads 10'h3FF next cycle -> p0_rsp_valid one cycle after the read handshake with rdata 4'hA; p1_rsp_valid stays 0.
REQ-037 Both ports hold valid reads for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1 and each response is routed to the correct port.
REQ-038 p1 alone is valid for 5 consecutive writes -> p1_req_ready=1 on all 5 cycles and ram_we=1 on all 5 cycles.
REQ-039 p0 read handshake at cycle T with rst=1 at T+1 -> no p0_rsp_valid, and all outputs at their reset values.
REQ-040 CLEAR_EN on, rst pulsed at clear address 500 -> clear restarts at address 0 and busy lasts a further 1024 cycles.
